// File: rtl/mem_arbiter_pkg.sv
// wisc_mem_pkg: shared FSM/owner types and bus width defaults for the memory arbiter.
package wisc_mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data request ports and memory command bus around the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = wisc_mem_pkg::ADDR_W,
  parameter int DATA_W = wisc_mem_pkg::DATA_W
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_rdy;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rdy;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_valid, mem_rdata,
    output i_rdy, i_rdata, d_rdy, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_valid, mem_rdata,
    input  i_rdy, i_rdata, d_rdy, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_sat_cnt.sv
// arb_sat_cnt: saturating up-counter with synchronous clear.
module arb_sat_cnt #(
  parameter int         W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != MAX) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: I/D arbitration onto one multi-cycle memory; optional ARB_PERF_EN adds perf counters.
module mem_arbiter #(
  parameter int ADDR_W = wisc_mem_pkg::ADDR_W,
  parameter int DATA_W = wisc_mem_pkg::DATA_W,
  parameter int STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
`ifdef ARB_PERF_EN
  output logic [15:0] perf_igrant,
  output logic [15:0] perf_dgrant,
  output logic [15:0] perf_istall,
`endif
  mem_arbiter_if.slave bus
);
  import wisc_mem_pkg::*;
  localparam logic [3:0] STREAK_MAX = 4'(STREAK);
  state_t            state, state_nxt;
  owner_t            owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;
  logic [3:0]        streak;
  logic              idle, cmd, i_ok, i_win, d_win, i_grant, d_grant;
  assign idle    = state == IDLE;
  assign cmd     = state == CMD;
  assign i_ok    = bus.i_req & ~hlt;
  // I only beats a pending D once D has had STREAK grants in a row
  assign i_win   = i_ok & (~bus.d_req | streak == STREAK_MAX);
  assign d_win   = bus.d_req & ~i_win;
  assign i_grant = idle & i_win;
  assign d_grant = idle & d_win;
  always_comb
    state_nxt = idle ? ((i_win | d_win) ? CMD : IDLE) :
                cmd ? WAIT :
                state == WAIT ? (bus.mem_valid ? RESP : WAIT) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (i_grant | d_grant) begin
        owner   <= i_grant ? OWN_I : OWN_D;
        we_q    <= d_grant & bus.d_we;
        addr_q  <= i_grant ? bus.i_addr : bus.d_addr;
        wdata_q <= bus.d_wdata;
      end
      if (state == WAIT && bus.mem_valid && !we_q) begin
        if (owner == OWN_I) i_rdata_q <= bus.mem_rdata;
        else d_rdata_q <= bus.mem_rdata;
      end
    end
  arb_sat_cnt #(.W(4), .MAX(STREAK_MAX)) u_streak (
    .clk(clk), .rst(rst),
    .inc(d_grant & i_ok),
    .clr(i_grant | (d_grant & ~i_ok)),
    .cnt(streak)
  );
  assign bus.mem_en    = cmd;
  assign bus.mem_we    = cmd & we_q;
  assign bus.mem_addr  = cmd ? addr_q : '0;
  assign bus.mem_wdata = cmd ? wdata_q : '0;
  assign bus.i_rdy     = state == RESP && owner == OWN_I;
  assign bus.d_rdy     = state == RESP && owner == OWN_D;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
`ifdef ARB_PERF_EN
  arb_sat_cnt #(.W(16)) u_perf_i (
    .clk(clk), .rst(rst), .inc(i_grant), .clr(1'b0), .cnt(perf_igrant)
  );
  arb_sat_cnt #(.W(16)) u_perf_d (
    .clk(clk), .rst(rst), .inc(d_grant), .clr(1'b0), .cnt(perf_dgrant)
  );
  arb_sat_cnt #(.W(16)) u_perf_s (
    .clk(clk), .rst(rst), .inc(bus.i_req & ~(~idle & owner == OWN_I)), .clr(1'b0), .cnt(perf_istall)
  );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a latency-programmable memory model.
module tb_mem_arbiter;
  import wisc_mem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hlt = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat = 1;
  int   cnt;
  logic [15:0] wmem [logic [15:0]];
  logic [15:0] rd;
`ifdef ARB_PERF_EN
  logic [15:0] perf_igrant, perf_dgrant, perf_istall;
`endif
  mem_arbiter_if bus ();
  mem_arbiter dut (
    .clk(clk),
    .rst(rst),
    .hlt(hlt),
`ifdef ARB_PERF_EN
    .perf_igrant(perf_igrant),
    .perf_dgrant(perf_dgrant),
    .perf_istall(perf_istall),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  // unwritten words read back as addr ^ 16'hA5B5
  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) wmem[bus.mem_addr] = bus.mem_wdata;
        rd = bus.mem_we ? 16'hDEAD : wmem.exists(bus.mem_addr) ? wmem[bus.mem_addr] : bus.mem_addr ^ 16'hA5B5;
        repeat (lat) @(posedge clk);
        #1 bus.mem_valid = 1'b1;
        bus.mem_rdata = rd;
        @(posedge clk);
        #1 bus.mem_valid = 1'b0;
        bus.mem_rdata = 16'h0;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic wait_en(input string tag);
    int n = 0;
    step();
    while (!bus.mem_en && n < 30) begin
      step();
      n++;
    end
    chk(tag, bus.mem_en, 1);
  endtask
  task automatic wait_rdy(input bit is_i, input string tag);
    int n = 0;
    step();
    while (!(is_i ? bus.i_rdy : bus.d_rdy) && n < 30) begin
      step();
      n++;
    end
    chk(tag, is_i ? bus.i_rdy : bus.d_rdy, 1);
  endtask
  initial begin
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) step();
    chk("rst_en", bus.mem_en, 0);
    chk("rst_irdy", bus.i_rdy, 0);
    chk("rst_drdy", bus.d_rdy, 0);
    chk("rst_irdata", bus.i_rdata, 0);
    chk("rst_drdata", bus.d_rdata, 0);
    chk("rst_addr", bus.mem_addr, 0);
    rst = 0;
    step();
    // single I read, memory answers two cycles after mem_en
    lat = 2;
    bus.i_req = 1; bus.i_addr = 16'h0010;
    step();
    chk("t1_en", bus.mem_en, 1);
    chk("t1_addr", bus.mem_addr, 16'h0010);
    chk("t1_we", bus.mem_we, 0);
    step();
    chk("t1_en_once", bus.mem_en, 0);
    step();
    chk("t1_rdy_early", bus.i_rdy, 0);
    step();
    chk("t1_rdy", bus.i_rdy, 1);
    chk("t1_rdata", bus.i_rdata, 16'hA5A5);
    bus.i_req = 0;
    step();
    chk("t1_rdy_pulse", bus.i_rdy, 0);
    // simultaneous I and D: D write first
    lat = 1;
    bus.i_req = 1; bus.i_addr = 16'h0020;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h1234;
    step();
    chk("t2_en", bus.mem_en, 1);
    chk("t2_we", bus.mem_we, 1);
    chk("t2_addr", bus.mem_addr, 16'h0200);
    chk("t2_wdata", bus.mem_wdata, 16'h1234);
    wait_rdy(0, "t2_drdy");
    chk("t2_irdy_idle", bus.i_rdy, 0);
    chk("t2_drdata_hold", bus.d_rdata, 0);
    bus.d_req = 0; bus.d_we = 0;
    step();
    chk("t2_idle_en", bus.mem_en, 0);
    step();
    chk("t2_i_en", bus.mem_en, 1);
    chk("t2_i_addr", bus.mem_addr, 16'h0020);
    chk("t2_i_we", bus.mem_we, 0);
    wait_rdy(1, "t2_irdy");
    chk("t2_irdata", bus.i_rdata, 16'hA595);
    bus.i_req = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    step();
    // starvation: four D grants, one I grant, then D again
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0300;
    bus.i_req = 1; bus.i_addr = 16'h0040;
    for (int g = 0; g < 4; g++) begin
      wait_en($sformatf("t3_d%0d_en", g));
      chk($sformatf("t3_d%0d_addr", g), bus.mem_addr, 16'h0300);
      chk($sformatf("t3_d%0d_streak", g), dut.streak, g + 1);
    end
    wait_en("t3_i_en");
    chk("t3_i_addr", bus.mem_addr, 16'h0040);
    chk("t3_i_streak", dut.streak, 0);
    step();
    step();
    chk("t3_irdy", bus.i_rdy, 1);
    chk("t3_irdata", bus.i_rdata, 16'hA5F5);
    chk("t3_drdata", bus.d_rdata, 16'hA6B5);
`ifdef ARB_PERF_EN
    chk("t6_dgrant", perf_dgrant, 4);
    chk("t6_igrant", perf_igrant, 1);
    chk("t6_istall", perf_istall, 17);
`endif
    bus.i_req = 0;
    wait_en("t3_d_resume_en");
    chk("t3_d_resume_addr", bus.mem_addr, 16'h0300);
    wait_rdy(0, "t3_d_resume_rdy");
    bus.d_req = 0;
    // halt blocks I; D still served; un-halt grants I next IDLE
    hlt = 1; bus.i_req = 1; bus.i_addr = 16'h0050;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      cnt += int'(bus.mem_en);
    end
    chk("t4_hlt_no_en", cnt, 0);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0200;
    wait_en("t4_d_en");
    chk("t4_d_addr", bus.mem_addr, 16'h0200);
    wait_rdy(0, "t4_drdy");
    chk("t4_drdata", bus.d_rdata, 16'h1234);
    bus.d_req = 0; hlt = 0;
    step();
    chk("t4_idle_en", bus.mem_en, 0);
    step();
    chk("t4_i_en", bus.mem_en, 1);
    chk("t4_i_addr", bus.mem_addr, 16'h0050);
    wait_rdy(1, "t4_irdy");
    chk("t4_irdata", bus.i_rdata, 16'hA5E5);
    bus.i_req = 0;
    step();
    // reset in WAIT; memory completes one cycle after release
    lat = 3;
    bus.i_req = 1; bus.i_addr = 16'h0060;
    wait_en("t5_en");
    step();
    rst = 1; bus.i_req = 0;
    step();
    chk("t5_state_rst", dut.state, IDLE);
    rst = 0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      cnt += int'(bus.i_rdy) + int'(bus.d_rdy) + int'(bus.mem_en);
    end
    chk("t5_no_pulse", cnt, 0);
    chk("t5_state", dut.state, IDLE);
    chk("t5_irdata", bus.i_rdata, 0);
    chk("t5_drdata", bus.d_rdata, 0);
    chk("t5_addr", bus.mem_addr, 0);
    chk("t5_we", bus.mem_we, 0);
    chk("t5_wdata", bus.mem_wdata, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
